imem_boot_loader: RTL and testbench

- Upstream stage of the RISCV single-cycle core. Receives a program image as a byte stream over a valid/ready link and writes it word-by-word into instruction memory.
- Holds the core in reset until the image is fully loaded and validated, then releases it so the core fetches from BASE_ADDR.
- Replaces the static memory-file preload for hardware bring-up and for self-checking benches.

---
 rtl/imem_boot_loader.sv | 201 ++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
`default_nettype none
// =============================================================================
// Module  : imem_boot_loader
// Brief   : Frame-based byte-stream loader for instruction memory; holds the
//           core in reset until the image is written. Optional trailing XOR
//           checksum is enabled by defining BOOT_CHECKSUM_EN.
// Revision: 1.0 - initial release
// =============================================================================
module imem_boot_loader #(
    parameter int                  INST_WIDTH = 32,
    parameter int                  PC_WIDTH   = 32,
    parameter int                  IMEM_DEPTH = 64,
    parameter logic [PC_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [PC_WIDTH-1:0]   imem_addr,
    output logic [INST_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset_n,
    output logic                  done,
    output logic                  error
);

    localparam int IDX_W = $clog2(IMEM_DEPTH + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN0 = 3'd1;
    localparam logic [2:0] ST_LEN1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;
`ifdef BOOT_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM = 3'd6;
    localparam logic [2:0] ST_END  = ST_CSUM;
`else
    localparam logic [2:0] ST_END  = ST_DONE;
`endif

    localparam logic [16:0] C_DEPTH = 17'(IMEM_DEPTH);

    logic [2:0]            state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [INST_WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  we_q, we_d;
    logic [PC_WIDTH-1:0]   addr_q, addr_d;
    logic [INST_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_rst_n_q, cpu_rst_n_d;
    logic                  rdy_q, rdy_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic                  w_accept;
    logic [15:0]           w_len_full;
    logic                  w_last_word;
    logic [PC_WIDTH-1:0]   w_word_addr;
    logic [INST_WIDTH-1:0] w_word_next;

    assign w_accept    = rx_valid && rdy_q;
    assign w_len_full  = {rx_data, len_q[7:0]};
    assign w_last_word = ((16'(idx_q) + 16'd1) == len_q);
    assign w_word_addr = BASE_ADDR + (PC_WIDTH'(idx_q) << 2);
    // Byte k of a word ends up in bits [8k+7:8k] after four right shifts.
    assign w_word_next = {rx_data, word_q[INST_WIDTH-1:8]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        idx_d       = idx_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_rst_n_d = cpu_rst_n_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept && (rx_data == 8'hA5)) begin
                    state_d = ST_LEN0;
                end
            end
            ST_LEN0: begin
                if (w_accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (w_accept) begin
                    len_d[15:8] = rx_data;
                    if ({1'b0, w_len_full} > C_DEPTH) begin
                        state_d = ST_ERR;
                    end else if (w_len_full == 16'd0) begin
                        state_d = ST_END;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    word_d = w_word_next;
                    cnt_d  = cnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = w_word_next;
                        addr_d  = w_word_addr;
                        idx_d   = idx_q + 1'b1;
                        if (w_last_word) begin
                            state_d = ST_END;
                        end
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (w_accept) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase

        // Status flags are registered alongside the state so they assert on entry.
        if (state_d == ST_DONE) begin
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
        end
        if (state_d == ST_ERR) begin
            error_d     = 1'b1;
            cpu_rst_n_d = 1'b0;
        end
        rdy_d = (state_d != ST_DONE) && (state_d != ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            rdy_q       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            rdy_q       <= rdy_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign rx_ready    = rdy_q;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_reset_n = cpu_rst_n_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// =============================================================================
// Module  : tb_imem_boot_loader
// Brief   : Frame-level reference model with a per-cycle write/status compare.
// Revision: 1.0 - initial release
// =============================================================================
module tb_imem_boot_loader;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset_n;
    logic        done;
    logic        error;

    imem_boot_loader #(
        .INST_WIDTH (32),
        .PC_WIDTH   (32),
        .IMEM_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_reset_n (cpu_reset_n),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  frame[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic        exp_done = 1'b0;
    logic        exp_err  = 1'b0;
    logic        prev_cpu = 1'b0;
    bit          chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Reference: parse the whole frame and list every write it must cause.
    task automatic model_frame();
        int          i = 0;
        int          n;
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        n = int'(frame[i+1]) + 256 * int'(frame[i+2]);
        i += 3;
        if (n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w = {frame[i+3], frame[i+2], frame[i+1], frame[i]};
            x = x ^ frame[i] ^ frame[i+1] ^ frame[i+2] ^ frame[i+3];
            exp_addr.push_back(BASE + 32'(4 * k));
            exp_data.push_back(w);
            i += 4;
        end
`ifdef BOOT_CHECKSUM_EN
        exp_done = (frame[i] == x);
        exp_err  = !exp_done;
`else
        exp_done = 1'b1;
`endif
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (imem_we === 1'b1) begin
                obs_addr.push_back(imem_addr);
                obs_data.push_back(imem_wdata);
                if (exp_addr.size() == 0) begin
                    check("extra_write", 32'(imem_we), 32'd0);
                end else begin
                    check("wr_addr", imem_addr, exp_addr.pop_front());
                    check("wr_data", imem_wdata, exp_data.pop_front());
                end
            end
            check("done_and_error", 32'(done & error), 32'd0);
            check("cpu_release_without_done", 32'(cpu_reset_n & ~done), 32'd0);
            if (cpu_reset_n && !prev_cpu) begin
                check("writes_before_release", 32'(exp_addr.size()), 32'd0);
            end
            prev_cpu = cpu_reset_n;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", imem_addr, BASE);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    // Entered just after a negedge; returns just after a negedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check("rx_ready_timeout", 32'(rx_ready), 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_frame(input int gap);
        obs_addr.delete();
        obs_data.delete();
        model_frame();
        foreach (frame[i]) send_byte(frame[i], gap);
        repeat (4) @(negedge clk);
        check("done", 32'(done), 32'(exp_done));
        check("error", 32'(error), 32'(exp_err));
        check("cpu_reset_n", 32'(cpu_reset_n), 32'(exp_done));
        check("rx_ready_final", 32'(rx_ready), 32'd0);
        check("pending_writes", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic load_frame1();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                  8'h93, 8'h01, 8'hC0, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        frame.push_back(8'h10);
`endif
    endtask

    task automatic pin_frame1(input string tag);
        check({tag, "_nwrites"}, 32'(obs_addr.size()), 32'd2);
        if (obs_addr.size() == 2) begin
            check({tag, "_addr0"}, obs_addr[0], 32'h0000_0000);
            check({tag, "_data0"}, obs_data[0], 32'h0050_0113);
            check({tag, "_addr1"}, obs_addr[1], 32'h0000_0004);
            check({tag, "_data1"}, obs_data[1], 32'h00C0_0193);
        end
        check({tag, "_done_lit"}, 32'(done), 32'd1);
    endtask

    initial begin
        do_reset();
        chk_on = 1'b1;

        // Back-to-back two-word image.
        load_frame1();
        run_frame(0);
        pin_frame1("t1");

        // Same image with three idle cycles between bytes.
        do_reset();
        load_frame1();
        run_frame(3);
        pin_frame1("t2");

        // Leading garbage before the header is discarded.
        do_reset();
        frame = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        frame.push_back(8'h13);
`endif
        run_frame(1);
        check("t3_nwrites", 32'(obs_addr.size()), 32'd1);
        if (obs_addr.size() == 1) begin
            check("t3_addr0", obs_addr[0], 32'h0000_0000);
            check("t3_data0", obs_data[0], 32'h0000_0013);
        end

        // Word count one above capacity.
        do_reset();
        frame = '{8'hA5, 8'h41, 8'h00};
        run_frame(0);
        check("t4_nwrites", 32'(obs_addr.size()), 32'd0);
        check("t4_error_lit", 32'(error), 32'd1);

`ifdef BOOT_CHECKSUM_EN
        // Bad checksum after a fully written image.
        do_reset();
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                  8'h93, 8'h01, 8'hC0, 8'h00, 8'h3C};
        run_frame(0);
        check("t5_nwrites", 32'(obs_addr.size()), 32'd2);
        check("t5_error_lit", 32'(error), 32'd1);
        check("t5_done_lit", 32'(done), 32'd0);
`endif

        // Reset in the middle of a load, then a full reload.
        do_reset();
        load_frame1();
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
        do_reset();
        run_frame(0);
        pin_frame1("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
